// File: rtl/cond_eval_unit.sv
// rtl/cond_eval_unit.sv - NZCV status register and per-slot ARM condition evaluation with registered valid/ready output
module cond_eval_unit #(
    parameter int         NUM_SLOTS = 1,
    parameter bit         BYPASS    = 1'b1,
    parameter logic [3:0] SR_RESET  = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sr_we,
    input  logic [3:0]             sr_in,
    output logic [3:0]             sr_q,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NUM_SLOTS-1:0] in_cond,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_SLOTS-1:0]   out_pass,
    output logic [3:0]             out_flags
);

    logic [3:0]           eval_flags;
    logic [NUM_SLOTS-1:0] pass_vec;
    logic                 accept;

    // Flags are {N,Z,C,V}; every one of the 16 codes is decoded explicitly.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        res = 1'b0;
        case (cond)
            4'h0: res = z;
            4'h1: res = ~z;
            4'h2: res = c;
            4'h3: res = ~c;
            4'h4: res = n;
            4'h5: res = ~n;
            4'h6: res = v;
            4'h7: res = ~v;
            4'h8: res = c & ~z;
            4'h9: res = ~c | z;
            4'hA: res = (n == v);
            4'hB: res = (n != v);
            4'hC: res = ~z & (n == v);
            4'hD: res = z | (n != v);
            4'hE: res = 1'b1;
            4'hF: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Forwarding lets a bundle see the flags of an S-instruction retiring this cycle.
    assign eval_flags = (BYPASS && sr_we) ? sr_in : sr_q;
    assign in_ready   = ~out_valid | out_ready;
    assign accept     = in_valid & in_ready;

    always_comb begin
        pass_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pass_vec[i] = cond_pass(in_cond[4*i +: 4], eval_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= SR_RESET;
            out_valid <= 1'b0;
            out_pass  <= '0;
            out_flags <= 4'h0;
        end else begin
            if (sr_we) begin
                sr_q <= sr_in;
            end
            // A flushed cycle drops any bundle offered alongside it.
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_pass  <= pass_vec;
                out_flags <= eval_flags;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cond_eval_unit.sv
// tb/tb_cond_eval_unit.sv - directed self-checking bench for cond_eval_unit
module tb_cond_eval_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_we;
    logic [3:0]  sr_in;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_cond;
    logic [15:0] in_cond_c;
    logic        out_ready;

    logic [3:0]  sr_q_a, sr_q_b, sr_q_c;
    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [0:0]  out_pass_a, out_pass_b;
    logic [3:0]  out_pass_c;
    logic [3:0]  out_flags_a, out_flags_b, out_flags_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cond_eval_unit #(.NUM_SLOTS(1), .BYPASS(1'b1), .SR_RESET(4'h0)) dut_a (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in), .sr_q(sr_q_a),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a), .in_cond(in_cond),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pass(out_pass_a),
        .out_flags(out_flags_a)
    );

    cond_eval_unit #(.NUM_SLOTS(1), .BYPASS(1'b0), .SR_RESET(4'h0)) dut_b (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in), .sr_q(sr_q_b),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b), .in_cond(in_cond),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pass(out_pass_b),
        .out_flags(out_flags_b)
    );

    cond_eval_unit #(.NUM_SLOTS(4), .BYPASS(1'b1), .SR_RESET(4'h0)) dut_c (
        .clk(clk), .rst(rst), .sr_we(sr_we), .sr_in(sr_in), .sr_q(sr_q_c),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c), .in_cond(in_cond_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_pass(out_pass_c),
        .out_flags(out_flags_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] z_table;
    logic [3:0]  sb_cond [6];
    logic        sb_exp  [6];
    logic        exp_q [$];
    int          sent, received, last_c;

    initial begin
        z_table = 16'b0110_0110_1010_1001;
        sb_cond = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h4, 4'h5};
        sb_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset with a bundle offered: nothing may be captured.
        rst = 1'b1; sr_we = 1'b0; sr_in = 4'h0; flush = 1'b0;
        in_valid = 1'b1; in_cond = 4'hE; in_cond_c = 16'hEEEE; out_ready = 1'b1;
        tick();
        check("rst_sr_q", 32'(sr_q_a), 32'h0);
        check("rst_valid_a", 32'(out_valid_a), 32'h0);
        check("rst_valid_c", 32'(out_valid_c), 32'h0);
        check("rst_pass_c", 32'(out_pass_c), 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("idle_valid", 32'(out_valid_a), 32'h0);

        // Z only, sweep every condition code.
        sr_we = 1'b1; sr_in = 4'b0100;
        tick();
        sr_we = 1'b0;
        check("sr_load", 32'(sr_q_a), 32'h4);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_cond = 4'(i);
            tick();
            check($sformatf("sweep_pass_%0h", i), 32'(out_pass_a), 32'(z_table[i]));
            check($sformatf("sweep_valid_%0h", i), 32'(out_valid_a), 32'h1);
        end
        check("sweep_flags", 32'(out_flags_a), 32'h4);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid_a), 32'h0);

        // HI / LS boundaries.
        sr_we = 1'b1; sr_in = 4'b0010;
        tick();
        sr_we = 1'b0; in_valid = 1'b1; in_cond = 4'h8;
        tick();
        check("hi_c", 32'(out_pass_a), 32'h1);
        in_valid = 1'b0; sr_we = 1'b1; sr_in = 4'b0110;
        tick();
        sr_we = 1'b0; in_valid = 1'b1; in_cond = 4'h8;
        tick();
        check("hi_cz", 32'(out_pass_a), 32'h0);
        in_cond = 4'h9;
        tick();
        check("ls_cz", 32'(out_pass_a), 32'h1);
        in_valid = 1'b0;

        // Same-cycle flag forwarding versus registered-only evaluation.
        sr_we = 1'b1; sr_in = 4'h0;
        tick();
        sr_in = 4'b0100; in_valid = 1'b1; in_cond = 4'h0;
        tick();
        sr_we = 1'b0;
        check("byp_pass_a", 32'(out_pass_a), 32'h1);
        check("byp_flags_a", 32'(out_flags_a), 32'h4);
        check("nobyp_pass_b", 32'(out_pass_b), 32'h0);
        check("nobyp_flags_b", 32'(out_flags_b), 32'h0);
        check("nobyp_sr_b", 32'(sr_q_b), 32'h4);
        tick();
        check("nobyp_next_b", 32'(out_pass_b), 32'h1);
        in_valid = 1'b0;
        tick();

        // Stall then release, tracked with a scoreboard (flags hold Z).
        sent = 0; received = 0; last_c = -1;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            in_valid  = (sent < 6);
            in_cond   = (sent < 6) ? sb_cond[sent] : 4'h0;
            #1;
            if (c >= 1 && c <= 3) begin
                check("stall_in_ready", 32'(in_ready_a), 32'h0);
                check("stall_valid", 32'(out_valid_a), 32'h1);
                check("stall_pass", 32'(out_pass_a), 32'h1);
                check("stall_flags", 32'(out_flags_a), 32'h4);
            end
            if (out_valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious", 32'h1, 32'h0);
                end else begin
                    check($sformatf("sb_item_%0d", received), 32'(out_pass_a), 32'(exp_q.pop_front()));
                end
                received++;
            end
            if (in_valid && in_ready_a) begin
                exp_q.push_back(sb_exp[sent]);
                sent++;
            end
            tick();
            if (received == 6) begin
                last_c = c;
                break;
            end
        end
        check("sb_received", 32'(received), 32'd6);
        check("sb_throughput", 32'(last_c), 32'd9);
        check("sb_no_dup", 32'(out_valid_a), 32'h0);

        // Four slots: slot0=EQ, slot1=NV, slot2=NE, slot3=AL with Z set.
        out_ready = 1'b1; in_valid = 1'b1; in_cond_c = 16'hE1F0; in_cond = 4'hE;
        tick();
        check("quad_pass", 32'(out_pass_c), 32'h9);
        check("quad_valid", 32'(out_valid_c), 32'h1);
        flush = 1'b1;
        tick();
        check("flush_valid_c", 32'(out_valid_c), 32'h0);
        check("flush_valid_a", 32'(out_valid_a), 32'h0);
        check("flush_sr", 32'(sr_q_c), 32'h4);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("post_flush_valid", 32'(out_valid_c), 32'h0);

        // Reset wins over a concurrent status write and bundle.
        rst = 1'b1; sr_we = 1'b1; sr_in = 4'hF; in_valid = 1'b1;
        tick();
        check("rst_dom_sr", 32'(sr_q_a), 32'h0);
        check("rst_dom_valid", 32'(out_valid_a), 32'h0);
        rst = 1'b0; sr_we = 1'b0; in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
